// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running H/V counters with registered sync/active/frame decode.
// Optional VGA_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module vga_timing_gen #(
  parameter int CNT_W    = 15,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FRAME_H  = 0,
  parameter int FRAME_V  = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             frame
`ifdef VGA_FRAME_CNT_EN
  ,output logic [15:0]     frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // One extra bit so region ends equal to 2^CNT_W still compare correctly.
  localparam logic [CNT_W:0] HA    = (CNT_W+1)'(H_ACTIVE);
  localparam logic [CNT_W:0] HS_LO = (CNT_W+1)'(H_ACTIVE + H_FP);
  localparam logic [CNT_W:0] HS_HI = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W:0] VA    = (CNT_W+1)'(V_ACTIVE);
  localparam logic [CNT_W:0] VS_LO = (CNT_W+1)'(V_ACTIVE + V_FP);
  localparam logic [CNT_W:0] VS_HI = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W:0] FH    = (CNT_W+1)'(FRAME_H);
  localparam logic [CNT_W:0] FV    = (CNT_W+1)'(FRAME_V);
  localparam bit FRAME_AT_ORIGIN   = (FRAME_H == 0) && (FRAME_V == 0);

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [CNT_W:0]   hx, vx;
  logic             hs_q, hs_d, vs_q, vs_d, act_q, act_d, frm_q, frm_d;
  logic             h_wrap, v_wrap;

  assign h_wrap = (h_q == H_LAST);
  assign v_wrap = (v_q == V_LAST);

  // Decode is taken from the next counter values so the registered outputs line up with the counts.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (pix_en) begin
      if (h_wrap) begin
        h_d = '0;
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    hx    = {1'b0, h_d};
    vx    = {1'b0, v_d};
    hs_d  = ((hx >= HS_LO) && (hx < HS_HI)) ? HS_POL : ~HS_POL;
    vs_d  = ((vx >= VS_LO) && (vx < VS_HI)) ? VS_POL : ~VS_POL;
    act_d = (hx < HA) && (vx < VA);
    frm_d = (hx == FH) && (vx == FV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      act_q <= 1'b1;
      frm_q <= FRAME_AT_ORIGIN;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      frm_q <= frm_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_q, fc_d;

  always_comb begin
    fc_d = fc_q;
    if (pix_en && h_wrap && v_wrap) fc_d = fc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fc_q <= '0;
    else     fc_q <= fc_d;
  end

  assign frame_count = fc_q;
`endif

  assign h_count = h_q;
  assign v_count = v_q;
  assign hsync   = hs_q;
  assign vsync   = vs_q;
  assign active  = act_q;
  assign frame   = frm_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator with its own horizontal and vertical counters.
- Replaces externally driven H/V counters feeding a purely combinational sync decoder.
- Produces hsync, vsync, active-video and frame-strobe signals, plus pixel coordinates for the renderer downstream.
- Sits between the pixel-clock enable source and the video/draw logic; all timings, polarities and counter width are set by parameters.

Parameters:
- CNT_W, 15, width of h_count/v_count; must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, horizontal sync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vertical sync width (lines).
- V_BP, 33, vertical back porch (lines).
- HS_POL, 0, hsync asserted level (0 = active-low).
- VS_POL, 0, vsync asserted level (0 = active-low).
- FRAME_H, 0, h_count value at which frame strobes.
- FRAME_V, 480, v_count value at which frame strobes (default = first blanking line).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- pix_en, input, 1, pixel tick; counters advance only on clk edges with pix_en=1.
- h_count, output, CNT_W, current pixel column.
- v_count, output, CNT_W, current line.
- hsync, output, 1, horizontal sync at HS_POL level when asserted.
- vsync, output, 1, vertical sync at VS_POL level when asserted.
- active, output, 1, high when the current position is visible.
- frame, output, 1, frame strobe.
- frame_count, output, 16, frames completed (present only with VGA_FRAME_CNT_EN).

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Horizontal counter on pix_en=1:
  - If h_count == H_TOTAL-1: h_count <= 0 and the vertical counter advances.
  - Otherwise: h_count <= h_count+1.
- Vertical counter, when advanced:
  - If v_count == V_TOTAL-1: v_count <= 0.
  - Otherwise: v_count <= v_count+1.
- pix_en=0: all registers hold.
- Outputs are registered and computed from the next counter values, so hsync/vsync/active/frame are cycle-aligned with h_count/v_count. There is zero latency between a count value and its decode.
- active = (h < H_ACTIVE) and (v < V_ACTIVE).
- Horizontal sync asserted when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751). hsync = HS_POL when asserted, ~HS_POL otherwise.
- Vertical sync asserted when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491). Encoding with VS_POL is the same as for hsync.
- Sync assertion depends only on its own counter. vsync changes at the h wrap into the relevant line.
- frame = 1 while h == FRAME_H and v == FRAME_V. It lasts exactly one pixel period (pix_en-to-pix_en), and one clk cycle when pix_en is tied high.
- All compares are unsigned at CNT_W bits; no count ever exceeds TOTAL-1.
- Reset (asynchronous, any time including mid-line):
  - h_count = 0, v_count = 0, active = 1.
  - hsync = ~HS_POL, vsync = ~VS_POL.
  - frame = 1 only if FRAME_H == 0 and FRAME_V == 0, else 0.
  - frame_count = 0.
- On rst deassertion, the first pix_en moves to (1,0).
- No other internal state exists; the block is a two-counter datapath with registered decode.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- Defined:
  - frame_count[15:0] port and register exist.
  - Increments by 1 on each pix_en edge where (h,v) wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Wraps 0xFFFF -> 0x0000. Reset value 0.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Reset, then pix_en held high for 800 clocks -> h_count runs 0..799 then returns to 0; v_count goes 0 -> 1 at that wrap; active high for h = 0..639 only.
- Default params, scan line 0 -> hsync low exactly for h = 656..751 (96 cycles), high elsewhere; vsync stays high.
- Run one full frame (420000 clocks) -> vsync low for v = 490..491 (1600 clocks); frame high for the single cycle at (0,480); counters return to (0,0).
- pix_en asserted every 4th clock -> counters step once per 4 clocks; frame high for 4 clocks; hsync low for 384 clocks.
- Assert rst at (h=300, v=200) -> outputs immediately show h=0, v=0, active=1, hsync=1, vsync=1, frame=0, before any clock edge.
- HS_POL=1, VS_POL=1, H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, with VGA_FRAME_CNT_EN defined -> hsync high for h = 10..12; vsync high on v = 5; frame_count increments every 112 pix_en ticks (16 x 7).
